// File: rtl/boxcar_interpolator.sv
// Purpose: interpolates by RATIO with a linear ramp from the previous sample to the new one.
// Latency: beat 0 is registered one cycle after acceptance; one input per RATIO+1 cycles at full rate.
// Backpressure: o_ready is high only in IDLE; i_ready low freezes the current beat without loss.
module boxcar_interpolator #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_RATIO = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int ACC_W = DATA_WIDTH + LOG2_RATIO;
  localparam logic [LOG2_RATIO-1:0] CNT_LAST = '1;
  localparam logic [LOG2_RATIO-1:0] CNT_ONE  = LOG2_RATIO'(1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [LOG2_RATIO-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   prev_q, prev_d;
  logic [DATA_WIDTH-1:0]   cur_q, cur_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;

  // The accumulator walks from RATIO*prev to RATIO*cur in steps of (new - prev).
  // The true sum never leaves [0, RATIO*(2^DATA_WIDTH-1)], so an ACC_W-bit
  // wrap-around add gives exactly the signed result without sign extension.
  logic [ACC_W-1:0] step_src;
  logic [ACC_W-1:0] acc_step;
  logic [ACC_W-1:0] acc_sum;

  // Select the new sample: the incoming one in IDLE, the held one while emitting.
  always_comb begin
    step_src = {{LOG2_RATIO{1'b0}}, cur_q};
    if (state_q == IDLE) begin
      step_src = {{LOG2_RATIO{1'b0}}, i_data};
    end
  end

  assign acc_step = step_src - {{LOG2_RATIO{1'b0}}, prev_q};
  assign acc_sum  = acc_q + acc_step;

  // Next-state and datapath decode; every register holds unless a handshake moves it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    acc_d     = acc_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          cur_d     = i_data;
          acc_d     = acc_sum;
          o_data_d  = acc_sum[ACC_W-1:LOG2_RATIO];
          o_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (o_valid_q && i_ready) begin
          if (cnt_q != CNT_LAST) begin
            acc_d    = acc_sum;
            o_data_d = acc_sum[ACC_W-1:LOG2_RATIO];
            cnt_d    = cnt_q + CNT_ONE;
          end else begin
            // Last beat already equals cur; acc now holds RATIO*cur, ready for the next ramp.
            o_valid_d = 1'b0;
            prev_d    = cur_q;
            state_d   = IDLE;
          end
        end
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight ramp and restarts from zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= '0;
      cur_q     <= '0;
      acc_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      cur_q     <= cur_d;
      acc_q     <= acc_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

endmodule

// File: tb/tb_boxcar_interpolator.sv
module tb_boxcar_interpolator;

  localparam int DW    = 8;
  localparam int LR    = 2;
  localparam int RATIO = 1 << LR;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;

  boxcar_interpolator #(.DATA_WIDTH(DW), .LOG2_RATIO(LR)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0]                din;
    logic [RATIO-1:0][DW-1:0]     exp;
  } vec_t;

  int             n_cmp;
  int             n_err;
  int             n_accept;
  logic [DW-1:0]  sb[$];
  logic [DW-1:0]  mprev;
  vec_t           vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    sb.delete();
    mprev = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  // Offer din until accepted in IDLE, pushing its beats; returns 1ns after the accepting edge.
  task automatic send(input logic [DW-1:0] din, input logic [RATIO-1:0][DW-1:0] ex);
    bit ok;
    ok = 1'b0;
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_data  = din;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        for (int j = 0; j < RATIO; j++) sb.push_back(ex[j]);
        ok = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    if (ok) mprev = din;
    else chk("send_timeout", 0, 1);
  endtask

  // Wait for the scoreboard to empty and the block to return to IDLE.
  task automatic drain(input bit rnd);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge i_clk);
      #1;
      if (rnd) i_ready = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      if (sb.size() == 0 && o_ready) done = 1'b1;
    end
    i_ready = 1'b1;
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  function automatic logic [RATIO-1:0][DW-1:0] model(input logic [DW-1:0] p, input logic [DW-1:0] c);
    logic [RATIO-1:0][DW-1:0] r;
    for (int j = 0; j < RATIO; j++)
      r[j] = DW'(((RATIO - 1 - j) * int'(p) + (j + 1) * int'(c)) / RATIO);
    return r;
  endfunction

  initial begin
    logic [DW-1:0] d;
    n_cmp = 0; n_err = 0; n_accept = 0;
    mprev = '0;
    i_reset_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;

    vecs[0] = '{din: 8'd20,  exp: {8'd20,  8'd40,  8'd60,  8'd80}};
    vecs[1] = '{din: 8'd0,   exp: {8'd0,   8'd5,   8'd10,  8'd15}};
    vecs[2] = '{din: 8'd255, exp: {8'd255, 8'd191, 8'd127, 8'd63}};
    vecs[3] = '{din: 8'd1,   exp: {8'd1,   8'd64,  8'd128, 8'd191}};
    vecs[4] = '{din: 8'd7,   exp: {8'd7,   8'd5,   8'd4,   8'd2}};

    fork
      forever begin
        @(negedge i_clk);
        if (i_reset_n) begin
          if (i_valid && o_ready) n_accept++;
          if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_beat: got %0d expected none at %0t", o_data, $time);
            end else begin
              d = sb.pop_front();
              chk("beat", int'(o_data), int'(d));
            end
          end
        end
      end
      begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values, o_ready decoded from IDLE even while held in reset.
    @(negedge i_clk);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_data",  int'(o_data),  0);
    chk("rst_o_ready", int'(o_ready), 1);
    do_reset();

    // First ramp: o_valid low before acceptance, high one cycle after.
    @(posedge i_clk);
    #1;
    i_valid = 1'b1; i_data = 8'd100;
    @(negedge i_clk);
    chk("pre_accept_o_valid", int'(o_valid), 0);
    chk("pre_accept_o_ready", int'(o_ready), 1);
    sb.push_back(8'd25); sb.push_back(8'd50); sb.push_back(8'd75); sb.push_back(8'd100);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    mprev = 8'd100;
    chk("post_accept_o_valid", int'(o_valid), 1);
    drain(1'b0);

    // Table: ramps in both directions; o_ready low for RATIO beats, back high right after.
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].din, vecs[v].exp);
      for (int j = 0; j < RATIO; j++) begin
        @(negedge i_clk);
        chk("emit_o_ready", int'(o_ready), 0);
        chk("emit_o_valid", int'(o_valid), 1);
      end
      @(negedge i_clk);
      chk("idle_o_ready", int'(o_ready), 1);
      chk("idle_o_valid", int'(o_valid), 0);
      drain(1'b0);
    end

    // Full scale from reset: acc reaches 1020 with no overflow.
    do_reset();
    send(8'd255, {8'd255, 8'd191, 8'd127, 8'd63});
    drain(1'b0);

    // Stall on beat 1 for 3 cycles: 50 held with o_valid high.
    do_reset();
    send(8'd100, {8'd100, 8'd75, 8'd50, 8'd25});
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("stall_o_valid", int'(o_valid), 1);
      chk("stall_o_data",  int'(o_data),  50);
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    drain(1'b0);

    // i_valid held with 200 through the ramp of 100: accepted exactly once.
    n_accept = 0;
    send(8'd100, {8'd100, 8'd100, 8'd100, 8'd100});
    i_valid = 1'b1; i_data = 8'd200;
    for (int j = 0; j < RATIO; j++) begin
      @(negedge i_clk);
      chk("held_valid_o_ready", int'(o_ready), 0);
    end
    send(8'd200, {8'd200, 8'd175, 8'd150, 8'd125});
    drain(1'b0);
    chk("accept_count", n_accept, 2);

    // Reset mid-ramp after beat 1: outputs clear at once, next ramp starts from 0.
    send(8'd100, model(mprev, 8'd100));
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("midrst_o_valid", int'(o_valid), 0);
    chk("midrst_o_data",  int'(o_data),  0);
    chk("midrst_o_ready", int'(o_ready), 1);
    sb.delete();
    mprev = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    send(8'd100, {8'd100, 8'd75, 8'd50, 8'd25});
    drain(1'b0);

    // Random samples with random downstream stalls against the reference model.
    for (int r = 0; r < 20; r++) begin
      d = DW'($urandom_range(0, 255));
      send(d, model(mprev, d));
      drain(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
